// File: rtl/wb_sel_arb.sv
// ============================================================================
// Module   : wb_sel_arb
// Summary  : N-source writeback result selector with fixed-priority or
//            round-robin arbitration and a one-entry output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_sel_arb #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int RR_MODE = 1,
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [SRC_W-1:0]           out_src,
  input  logic                       out_ready
);

  localparam logic [SRC_W-1:0] C_LAST_IDX = SRC_W'(NUM_SRC - 1);

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_data;
  logic [SRC_W-1:0]     r_out_src;
  logic [SRC_W-1:0]     r_ptr;

  logic                 w_load_en;
  logic                 w_gnt_any;
  logic [SRC_W-1:0]     w_gnt_idx;
  logic                 w_xfer;
  logic [WIDTH-1:0]     w_sel_data;
  logic [SRC_W-1:0]     w_ptr_nxt;

  function automatic logic [SRC_W-1:0] f_lowest(input logic [NUM_SRC-1:0] v);
    f_lowest = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = SRC_W'(i);
    end
  endfunction

  assign w_load_en = !r_out_valid || out_ready;
  assign w_gnt_any = |src_valid;

  generate
    if (RR_MODE != 0) begin : g_rr
      logic [NUM_SRC-1:0] w_mask;
      logic [NUM_SRC-1:0] w_req_hi;

      for (genvar i = 0; i < NUM_SRC; i++) begin : g_mask
        assign w_mask[i] = (SRC_W'(i) >= r_ptr);
      end

      // Requests at or above the pointer take precedence; otherwise wrap to
      // the lowest-index request below it.
      assign w_req_hi  = src_valid & w_mask;
      assign w_gnt_idx = (|w_req_hi) ? f_lowest(w_req_hi) : f_lowest(src_valid);
    end else begin : g_fp
      assign w_gnt_idx = f_lowest(src_valid);
    end
  endgenerate

  assign w_xfer = w_load_en && w_gnt_any;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_rdy
      assign src_ready[i] = rst_n && w_xfer && (w_gnt_idx == SRC_W'(i));
    end
  endgenerate

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_gnt_idx == SRC_W'(i)) w_sel_data = src_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == C_LAST_IDX) ? '0 : w_gnt_idx + SRC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_src   <= w_gnt_idx;
        r_ptr       <= w_ptr_nxt;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

`default_nettype wire

// File: tb/tb_wb_sel_arb.sv
// ============================================================================
// Module   : tb_wb_sel_arb
// Summary  : Bench for wb_sel_arb (round-robin, fixed-priority, single-source).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_sel_arb;

  logic         clk;
  logic         rst_n;
  logic [3:0]   src_valid;
  logic [127:0] src_data;
  logic         out_ready;
  int           sel;

  logic [3:0]  v_rr, v_fp, rdy_rr, rdy_fp;
  logic        v_one, rdy_one, ov_rr, ov_fp, ov_one;
  logic [31:0] od_rr, od_fp, od_one;
  logic [1:0]  os_rr, os_fp;
  logic [0:0]  os_one;

  logic [3:0]  obs_rdy;
  logic        obs_ov;
  logic [31:0] obs_od;
  logic [1:0]  obs_os;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit        m_valid;
  bit [31:0] m_data;
  int        m_src;
  int        m_ptr;
  int        wait_cnt [4];

  assign v_rr  = (sel == 0) ? src_valid : 4'b0;
  assign v_fp  = (sel == 1) ? src_valid : 4'b0;
  assign v_one = (sel == 2) ? src_valid[0] : 1'b0;

  wb_sel_arb #(.WIDTH(32), .NUM_SRC(4), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .src_valid(v_rr), .src_data(src_data),
    .src_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_src(os_rr),
    .out_ready(out_ready));

  wb_sel_arb #(.WIDTH(32), .NUM_SRC(4), .RR_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .src_valid(v_fp), .src_data(src_data),
    .src_ready(rdy_fp), .out_valid(ov_fp), .out_data(od_fp), .out_src(os_fp),
    .out_ready(out_ready));

  wb_sel_arb #(.WIDTH(32), .NUM_SRC(1), .RR_MODE(1)) u_one (
    .clk(clk), .rst_n(rst_n), .src_valid(v_one), .src_data(src_data[31:0]),
    .src_ready(rdy_one), .out_valid(ov_one), .out_data(od_one), .out_src(os_one),
    .out_ready(out_ready));

  always_comb begin
    obs_rdy = rdy_rr; obs_ov = ov_rr; obs_od = od_rr; obs_os = os_rr;
    if (sel == 1) begin
      obs_rdy = rdy_fp; obs_ov = ov_fp; obs_od = od_fp; obs_os = os_fp;
    end else if (sel == 2) begin
      obs_rdy = {3'b000, rdy_one}; obs_ov = ov_one; obs_od = od_one;
      obs_os  = {1'b0, os_one};
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_src();
    return (sel == 2) ? 1 : 4;
  endfunction

  // Grant chosen by the arbitration rules given the model's current state.
  function automatic int model_grant();
    int n = n_src();
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < n; k++) begin
      int idx = (sel == 0) ? (m_ptr + k) % n : k;
      if (src_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endtask

  // One cycle: drive inputs, check handshake, clock, check output register.
  task automatic step(input logic [3:0] v, input logic ordy, output int g);
    logic [3:0] exp_rdy;
    src_valid = v;
    out_ready = ordy;
    #1;
    g = model_grant();
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("src_ready", 64'(obs_rdy), 64'(exp_rdy));
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1;
      m_data  = src_data[g*32 +: 32];
      m_src   = g;
      m_ptr   = (g + 1) % n_src();
    end else if (ordy) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", 64'(obs_ov), 64'(m_valid));
    chk("out_data",  64'(obs_od), 64'(m_data));
    chk("out_src",   64'(obs_os), 64'(m_src));
  endtask

  task automatic do_reset(input int which);
    @(negedge clk);
    sel = which;
    src_valid = 4'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_valid", 64'(obs_ov), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : main
    int g;
    int pend;
    sel = 0; rst_n = 1'b1; src_valid = 4'b0; src_data = '0; out_ready = 1'b0;
    model_reset();

    // Reset and idle; src_ready stays low during reset even with requests
    @(negedge clk);
    rst_n = 1'b0;
    src_valid = 4'b1111;
    #1;
    chk("rst_out_valid", 64'(obs_ov), 64'd0);
    chk("rst_out_data",  64'(obs_od), 64'd0);
    chk("rst_out_src",   64'(obs_os), 64'd0);
    chk("rst_src_ready", 64'(obs_rdy), 64'd0);
    src_valid = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) step(4'b0000, k[0], g);

    // Single transfer and latency
    src_data[2*32 +: 32] = 32'hDEAD_BEEF;
    step(4'b0100, 1'b1, g);
    chk("single_out_data", 64'(obs_od), 64'hDEAD_BEEF);
    chk("single_out_src",  64'(obs_os), 64'd2);
    step(4'b0000, 1'b1, g);
    chk("single_drain", 64'(obs_ov), 64'd0);

    // Round-robin fairness
    do_reset(0);
    for (int i = 0; i < 4; i++) src_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    for (int k = 0; k < 6; k++) begin
      step(4'b1111, 1'b1, g);
      chk("rr_seq", 64'(obs_os), 64'(k % 4));
    end

    // Fixed priority
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      step(4'b1010, 1'b1, g);
      chk("fp_src", 64'(obs_os), 64'd1);
    end

    // Back-pressure
    do_reset(0);
    src_data[31:0] = 32'h0000_00AA;
    step(4'b0001, 1'b1, g);
    for (int k = 0; k < 5; k++) begin
      step(4'b0011, 1'b0, g);
      chk("stall_data", 64'(obs_od), 64'hAA);
    end
    src_valid = 4'b0011; out_ready = 1'b1;
    #1;
    chk("stall_release_rdy", 64'(obs_rdy), 64'b0010);
    step(4'b0011, 1'b1, g);
    chk("stall_release_src", 64'(obs_os), 64'd1);

    // Asynchronous reset mid-operation with ptr=2
    do_reset(0);
    step(4'b0010, 1'b0, g);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", 64'(obs_ov), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    src_valid = 4'b1111; out_ready = 1'b1;
    #1;
    chk("post_rst_grant", 64'(obs_rdy), 64'b0001);
    step(4'b1111, 1'b1, g);

    // Randomised traffic: sources hold request and data until accepted
    for (int s = 0; s < 3; s++) begin
      do_reset(s);
      pend = 0;
      for (int c = 0; c < 300; c++) begin
        for (int i = 0; i < n_src(); i++) begin
          if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
            pend[i] = 1'b1;
            src_data[i*32 +: 32] = $urandom;
          end
        end
        step(4'(pend), ($urandom_range(0, 9) < 7), g);
        if (g >= 0) begin
          if (s == 0) chk("starvation", 64'(wait_cnt[g] < 4), 64'd1);
          pend[g] = 1'b0;
          wait_cnt[g] = 0;
          for (int i = 0; i < 4; i++) if (pend[i]) wait_cnt[i]++;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_sel_arb.md
Name: wb_sel_arb

Overview:
Parametrised N-source result selector that grows the datapath's plain 2:1 word mux into an arbitrated, registered selector for the multi-cycle RISC-V core. Each source (ALU, load unit, multiplier, CSR, …) offers a result word with a valid/ready handshake. The block picks one source per cycle, using fixed-priority or round-robin arbitration, and holds the winner in a one-entry output register that feeds register-file writeback. Back-pressure from writeback stalls the sources.

Parameters:
WIDTH, 32, data word width in bits (1..64)
NUM_SRC, 4, number of input sources (1..16)
RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
SRC_W, $clog2(NUM_SRC) with a minimum of 1, width of the source index (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
src_valid  in  NUM_SRC  per-source result valid
src_data  in  NUM_SRC*WIDTH  flattened source words; source i occupies bits [i*WIDTH +: WIDTH]
src_ready  out  NUM_SRC  per-source accept, one-hot or zero
out_valid  out  1  output register holds a result
out_data  out  WIDTH  selected word
out_src  out  SRC_W  index of the source that produced out_data
out_ready  in  1  writeback consumes out_data this cycle

Behaviour:
- Reset is asynchronous and active-low: one clock; reset is asynchronous and active-low, on ports clk and rst_n.
- Reset values while rst_n=0:
  - out_valid=0, out_data=0, out_src=0
  - round-robin pointer=0
  - src_ready forced to all zeros
- Load enable: load_en = !out_valid | out_ready. The output register accepts a new word when it is empty or being drained in the same cycle, so back-to-back transfers run at full rate.
- Grant (combinational):
  - RR_MODE=0: lowest-index i with src_valid[i]=1.
  - RR_MODE=1: first i with src_valid[i]=1, searching ptr, ptr+1, …, NUM_SRC-1, 0, …, ptr-1 (modulo NUM_SRC).
  - No valid source: no grant.
- src_ready = onehot(grant) when load_en=1, otherwise 0. src_ready never depends on src_valid of a non-granted source. It may depend on out_ready combinationally.
- Transfer: src i transfers when src_valid[i] & src_ready[i]. On that clock edge:
  - out_data <= src_data[i]
  - out_src <= i
  - out_valid <= 1
- Latency: exactly 1 cycle from the accepting edge to out_valid=1.
- Drain: out_ready=1 with out_valid=1 and no transfer clears out_valid on the next edge. out_data and out_src keep their last values; they are don't-care when out_valid=0 but must not be X.
- Stall: out_valid=1 and out_ready=0 hold out_data and out_src stable, with src_ready=0 for every source.
- Round-robin pointer:
  - Updates only on a transfer, to (i+1) mod NUM_SRC; wraps NUM_SRC-1 → 0.
  - Unchanged on idle or stall cycles.
  - Ignored when RR_MODE=0.
- Simultaneous drain and load (out_valid=1, out_ready=1, transfer): the new word replaces the old one and out_valid stays 1. No bubble, no loss.
- Source protocol: a source must hold src_valid and its data until it is accepted. The block does not check this; the bench asserts it.
- NUM_SRC=1: the arbiter degenerates to a registered pipe stage, and out_src is constant 0.
- Reset asserted mid-transfer: the pending output word is discarded, out_valid drops asynchronously, and ptr returns to 0.
- Starvation bound (RR_MODE=1): a continuously valid source is granted within NUM_SRC transfers.

Test Plan:
1. Reset and idle. Set rst_n=0, then release with all src_valid=0 → out_valid=0, out_data=0, src_ready=4'b0000 for 10 cycles.
2. Single transfer and latency. Present src_valid=4'b0100 with source 2 data 32'hDEAD_BEEF and out_ready=1 → src_ready=4'b0100 in that cycle. On the next cycle out_valid=1, out_data=32'hDEAD_BEEF and out_src=2; out_valid clears one cycle later.
3. Round-robin fairness. Set RR_MODE=1, src_valid=4'b1111 held, out_ready=1, and source i data = 32'h1000_0000+i → out_src sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
4. Fixed-priority mode. Set RR_MODE=0, src_valid=4'b1010 held → out_src=1 every cycle and src_ready[3] never asserted.
5. Back-pressure. Hold out_ready=0 after out_data=32'h0000_00AA (src 0) is loaded, with src_valid=4'b0011 → out_data stays 32'h0000_00AA and src_ready=0 for 5 cycles. When out_ready=1 is raised, src 1 is accepted the same cycle (ptr=1) and out_src=1 follows one cycle later.
6. Asynchronous reset mid-operation. Drop rst_n between clock edges while out_valid=1 and ptr=2 → out_valid=0 immediately, without waiting for a clock edge. After release, with src_valid=4'b1111, the first grant is source 0.
